// File: rtl/bitstream_packer.sv
// bitstream_packer: packs a serial bit stream MSB-first into WIDTH-bit words
// and buffers them in a 2-entry FIFO that drops words when full (no backpressure).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_bit, in_valid       serial input bit and its qualifier
//   flush                  discard the partial word
//   clr_ovf                clear the sticky overflow flag
//   out_data, out_valid    FIFO head word and non-empty flag
//   out_ready              consumer accepts the head word
//   bit_cnt                bits held in the partial word
//   word_cnt               words pushed since reset, wrapping
//   overflow               sticky: a completed word was dropped
module bitstream_packer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_bit,
    input  logic                     in_valid,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic [CNT_W-1:0]         word_cnt,
    output logic                     overflow
);
    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST = BC_W'(WIDTH - 1);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] shreg, head, tail, head_nxt, tail_nxt, word;
    logic accept, done, pop, push, drop;

    assign accept    = in_valid && !flush;
    assign done      = accept && (bit_cnt == LAST);
    assign word      = {shreg[WIDTH-2:0], in_bit};
    assign out_valid = (state != EMPTY);
    assign out_data  = head;
    assign pop       = out_valid && out_ready;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push      = done && ((state != FULL) || pop);
    assign drop      = done && !push;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: if (push) begin
                state_nxt = ONE;
                head_nxt  = word;
            end
            ONE: if (push && pop) begin
                head_nxt = word;
            end else if (push) begin
                state_nxt = FULL;
                tail_nxt  = word;
            end else if (pop) begin
                state_nxt = EMPTY;
            end
            FULL: if (pop) begin
                head_nxt = tail;
                if (push) tail_nxt = word;
                else state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            head     <= head_nxt;
            tail     <= tail_nxt;
            if (accept) shreg <= word;
            bit_cnt  <= flush ? '0 : !accept ? bit_cnt : done ? '0 : bit_cnt + 1'b1;
            if (push) word_cnt <= word_cnt + 1'b1;
            // A drop in the same cycle as clr_ovf keeps the flag set.
            overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end
endmodule

// File: tb/tb_bitstream_packer.sv
// tb_bitstream_packer: directed self-checking bench for bitstream_packer (WIDTH=8),
// with a second instance using a 2-bit word counter to exercise counter wrap.
module tb_bitstream_packer;
    logic       clk = 1'b0;
    logic       rst, in_bit, in_valid, flush, clr_ovf, out_ready;
    logic [7:0] out_data, s_data;
    logic       out_valid, overflow, s_valid, s_ovf;
    logic [2:0] bit_cnt, s_bcnt;
    logic [15:0] word_cnt;
    logic [1:0] s_wcnt;
    int n_asrt = 0;
    int n_fail = 0;

    bitstream_packer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .flush(flush),
        .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .bit_cnt(bit_cnt), .word_cnt(word_cnt), .overflow(overflow)
    );

    bitstream_packer #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .flush(flush),
        .clr_ovf(clr_ovf), .out_data(s_data), .out_valid(s_valid),
        .out_ready(out_ready), .bit_cnt(s_bcnt), .word_cnt(s_wcnt), .overflow(s_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bitin(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        tick();
    endtask

    task automatic word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) bitin(w[i]);
    endtask

    initial begin
        rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; flush = 1'b0;
        clr_ovf = 1'b0; out_ready = 1'b1;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_bcnt", bit_cnt, 0);
        chk("rst_wcnt", word_cnt, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;

        // 1: single word B2, consumer always ready
        word(8'hB2);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 8'hB2);
        chk("t1_wcnt", word_cnt, 1);
        chk("t1_bcnt", bit_cnt, 0);
        in_valid = 1'b0;
        tick();
        chk("t1_valid_gone", out_valid, 0);

        // 2: fill FIFO, drop the third word, then drain
        out_ready = 1'b0;
        word(8'hA5);
        chk("t2_first_valid", out_valid, 1);
        word(8'h3C);
        chk("t2_full_ovf", overflow, 0);
        word(8'hFF);
        in_valid = 1'b0;
        chk("t2_ovf", overflow, 1);
        chk("t2_wcnt", word_cnt, 3);
        chk("t2_head", out_data, 8'hA5);
        tick();
        chk("t2_stable_data", out_data, 8'hA5);
        chk("t2_stable_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("t2_second", out_data, 8'h3C);
        chk("t2_second_valid", out_valid, 1);
        tick();
        chk("t2_drained", out_valid, 0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t2_clr_ovf", overflow, 0);

        // 3: push and pop together while full
        out_ready = 1'b0;
        word(8'h11);
        word(8'h22);
        for (int i = 7; i >= 1; i--) bitin(1'(8'h5A >> i));
        out_ready = 1'b1;
        bitin(1'b0);
        in_valid = 1'b0;
        chk("t3_ovf", overflow, 0);
        chk("t3_wcnt", word_cnt, 6);
        chk("t3_head", out_data, 8'h22);
        tick();
        chk("t3_last", out_data, 8'h5A);
        chk("t3_last_valid", out_valid, 1);
        tick();
        chk("t3_drained", out_valid, 0);

        // 4: flush discards partial word, flush-cycle bit ignored
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) bitin(1'b1);
        chk("t4_bcnt5", bit_cnt, 5);
        flush = 1'b1; in_bit = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_bcnt", bit_cnt, 0);
        chk("t4_no_stray", out_valid, 0);
        word(8'h81);
        in_valid = 1'b0;
        chk("t4_data", out_data, 8'h81);
        chk("t4_valid", out_valid, 1);
        chk("t4_bcnt", bit_cnt, 0);
        chk("t4_wcnt", word_cnt, 7);

        // 5: async reset mid-word with data buffered and overflow set
        word(8'h01);
        word(8'h02);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        bitin(1'b1); bitin(1'b1); bitin(1'b1);
        in_valid = 1'b0;
        chk("t5_pre_bcnt", bit_cnt, 3);
        chk("t5_pre_ovf", overflow, 1);
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_data", out_data, 8'h01);
        chk("t5_pre_wcnt", word_cnt, 8);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_bcnt", bit_cnt, 0);
        chk("t5_wcnt", word_cnt, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_data", out_data, 0);
        rst = 1'b0;
        tick();

        // 6: counter wrap on the 2-bit instance, then drop beats clr_ovf
        out_ready = 1'b1;
        word(8'h11); word(8'h22); word(8'h33);
        chk("t6_small_3", s_wcnt, 3);
        chk("t6_big_3", word_cnt, 3);
        word(8'h44);
        in_valid = 1'b0;
        chk("t6_small_wrap", s_wcnt, 0);
        chk("t6_big_4", word_cnt, 4);
        chk("t6_data", s_data, 8'h44);
        tick();
        out_ready = 1'b0;
        word(8'h55); word(8'h66);
        chk("t6_ovf_before", overflow, 0);
        clr_ovf = 1'b1;
        word(8'h77);
        in_valid = 1'b0;
        chk("t6_ovf_set_wins", overflow, 1);
        chk("t6_wcnt_drop", word_cnt, 6);
        chk("t6_small_drop", s_wcnt, 2);
        tick();
        clr_ovf = 1'b0;
        chk("t6_ovf_cleared", overflow, 0);
        chk("t6_head", out_data, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
